// File: rtl/regfile_cmd_sequencer_pkg.sv
// Shared definitions for the file-register command sequencer: default sizes
// and the sequencer FSM state encoding.
package regfile_cmd_sequencer_pkg;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_NUM_REGS        = 32;
    localparam int DEF_ADDR_W          = 5;
    localparam int DEF_DATA_W          = 32;
    localparam int SW_DATA_W           = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_VWAIT  = 3'd2,
        ST_VCHECK = 3'd3,
        ST_CLEAR  = 3'd4
    } state_e;

endpackage

// File: rtl/regfile_cmd_sequencer_key_debounce.sv
// Raw key conditioner: two-flop synchronizer, stable-level debounce counter
// and a single-cycle rising-edge pulse on the accepted level.
module regfile_cmd_sequencer_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic pulse
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             level_dly_q, level_dly_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accept a new level only after it differs from the current one for
    // DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
    always_comb begin
        sync1_d     = key_raw;
        sync2_d     = sync1_q;
        level_d     = level_q;
        level_dly_d = level_q;
        cnt_d       = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Synchronizer, debounce counter and edge-detect history.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            cnt_q       <= cnt_d;
        end
    end

    assign pulse = level_q & ~level_dly_q;

endmodule

// File: rtl/regfile_cmd_sequencer.sv
// Command stage in front of file_register: turns debounced key presses into a
// single write followed by a readback check, or a full-depth clear sweep.
module regfile_cmd_sequencer
    import regfile_cmd_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int NUM_REGS        = DEF_NUM_REGS,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_write,
    input  logic              key_clear,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic [7:0]        sw_data,
    output logic              we,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic [ADDR_W-1:0] read1_addr,
    input  logic [DATA_W-1:0] read_data,
    output logic [7:0]        led_data,
    output logic              busy,
    output logic              verify_err
);

    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(NUM_REGS - 1);

    logic write_pulse, clear_pulse;

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      waddr_q, waddr_d;
    logic [SW_DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]      rd_addr_q, rd_addr_d;
    logic [7:0]             led_q, led_d;
    logic                   err_q, err_d;
    logic [ADDR_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]      wdata_ext;

    regfile_cmd_sequencer_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_write (
        .clk    (clk),
        .rst    (rst),
        .key_raw(key_write),
        .pulse  (write_pulse)
    );

    regfile_cmd_sequencer_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clear (
        .clk    (clk),
        .rst    (rst),
        .key_raw(key_clear),
        .pulse  (clear_pulse)
    );

    // Payload is only 8 switches wide; the upper bits are always zero.
    assign wdata_ext = {{(DATA_W-SW_DATA_W){1'b0}}, wdata_q};

    // Next-state and register updates; pulses are only honoured in IDLE,
    // so anything arriving while busy is simply lost.
    always_comb begin
        state_d   = state_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        rd_addr_d = rd_addr_q;
        led_d     = led_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                rd_addr_d = sw_addr;
                led_d     = read_data[7:0];
                if (clear_pulse) begin
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end else if (write_pulse) begin
                    waddr_d = sw_addr;
                    wdata_d = sw_data;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                rd_addr_d = waddr_q;
                state_d   = ST_VWAIT;
            end
            ST_VWAIT: begin
                state_d = ST_VCHECK;
            end
            ST_VCHECK: begin
                led_d   = read_data[7:0];
                err_d   = err_q | (read_data != wdata_ext);
                state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            waddr_q   <= '0;
            wdata_q   <= '0;
            rd_addr_q <= '0;
            led_q     <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            rd_addr_q <= rd_addr_d;
            led_q     <= led_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    // Write port is decoded from state so reset drops we on the same edge.
    assign we         = (state_q == ST_WRITE) || (state_q == ST_CLEAR);
    assign write_addr = (state_q == ST_CLEAR) ? cnt_q : waddr_q;
    assign write_data = (state_q == ST_CLEAR) ? '0 : wdata_ext;
    assign read1_addr = rd_addr_q;
    assign led_data   = led_q;
    assign busy       = (state_q != ST_IDLE);
    assign verify_err = err_q;

endmodule

// File: tb/tb_regfile_cmd_sequencer.sv
// Bench for regfile_cmd_sequencer: a behavioural 32x32 register file with a
// one-clock read, a write-port log, and a byte-level shadow of what the
// register file should hold after each accepted command.
`timescale 1ns/1ps
module tb_regfile_cmd_sequencer;

    localparam int DEB  = 4;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic          clk = 1'b0;
    logic          rst, key_write, key_clear;
    logic [AW-1:0] sw_addr;
    logic [7:0]    sw_data;
    logic          we;
    logic [AW-1:0] write_addr, read1_addr;
    logic [DW-1:0] write_data, read_data;
    logic [7:0]    led_data;
    logic          busy, verify_err;

    always #5 clk = ~clk;

    regfile_cmd_sequencer #(.DEBOUNCE_CYCLES(DEB), .NUM_REGS(NREG), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .key_write(key_write), .key_clear(key_clear),
        .sw_addr(sw_addr), .sw_data(sw_data), .we(we), .write_addr(write_addr),
        .write_data(write_data), .read1_addr(read1_addr), .read_data(read_data),
        .led_data(led_data), .busy(busy), .verify_err(verify_err)
    );

    // Register file model; corrupt7 flips bit 0 of any readback from addr 7.
    logic [DW-1:0] mem [NREG];
    logic [DW-1:0] rd_q;
    logic          preload, corrupt7;
    logic [DW-1:0] pre_val;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NREG; i++) mem[i] <= pre_val;
        end else if (we) begin
            mem[write_addr] <= write_data;
        end
        rd_q <= (corrupt7 && read1_addr == 7) ? (mem[read1_addr] ^ 32'h1) : mem[read1_addr];
    end
    assign read_data = rd_q;

    // Write-port log sampled mid-cycle.
    typedef struct {
        int            cyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t wlog[$];
    int  cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wr_t e;
            e.cyc  = cyc;
            e.addr = write_addr;
            e.data = write_data;
            wlog.push_back(e);
        end
    end

    logic [7:0] ref_mem [NREG];
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        @(negedge clk);
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_idle"}, busy, 1'b0);
        @(posedge clk); #1;
    endtask

    // Press keys for 'hold' clocks, let the command run, then let the
    // debounced levels fall before returning.
    task automatic do_op(input string name, input bit w, input bit c, input int hold);
        key_write = w;
        key_clear = c;
        repeat (hold) @(posedge clk);
        #1;
        key_write = 1'b0;
        key_clear = 1'b0;
        repeat (DEB + 4) @(posedge clk);
        #1;
        wait_idle(name, 80);
        repeat (DEB + 4) @(posedge clk);
        #1;
    endtask

    task automatic check_write_log(input string name, input logic [AW-1:0] a, input logic [7:0] d);
        chk({name, "_count"}, wlog.size(), 1);
        if (wlog.size() > 0) begin
            chk({name, "_addr"}, wlog[0].addr, a);
            chk({name, "_data"}, wlog[0].data, {24'h0, d});
        end
        wlog.delete();
    endtask

    task automatic check_clear_log(input string name, input int exp_n);
        bit ok = 1'b1;
        chk({name, "_count"}, wlog.size(), exp_n);
        foreach (wlog[i]) begin
            if (wlog[i].addr != AW'(i) || wlog[i].data != '0 || wlog[i].cyc != wlog[0].cyc + i) ok = 1'b0;
        end
        chk({name, "_seq"}, ok, 1'b1);
        wlog.delete();
    endtask

    // Idle live monitor: address -> read1_addr -> read_data -> led_data.
    task automatic live_check(input string name, input logic [AW-1:0] a, input logic [7:0] exp);
        sw_addr = a;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(name, led_data, exp);
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        int            hold;
        logic [31:0]   exp_wdata;
        logic [7:0]    exp_led;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int lat;
        int t;
        logic [AW-1:0] ra;
        logic [7:0]    rd;

        vecs[0] = '{addr: 5'd5,  data: 8'hA5, hold: 10, exp_wdata: 32'h000000A5, exp_led: 8'hA5};
        vecs[1] = '{addr: 5'd0,  data: 8'h00, hold: DEB, exp_wdata: 32'h00000000, exp_led: 8'h00};
        vecs[2] = '{addr: 5'd31, data: 8'hFF, hold: 7,  exp_wdata: 32'h000000FF, exp_led: 8'hFF};
        vecs[3] = '{addr: 5'd5,  data: 8'h3C, hold: 20, exp_wdata: 32'h0000003C, exp_led: 8'h3C};
        vecs[4] = '{addr: 5'd16, data: 8'h81, hold: 5,  exp_wdata: 32'h00000081, exp_led: 8'h81};

        rst = 1'b1; key_write = 1'b0; key_clear = 1'b0; sw_addr = '0; sw_data = '0;
        preload = 1'b1; pre_val = '0; corrupt7 = 1'b0;
        for (int i = 0; i < NREG; i++) ref_mem[i] = 8'h00;

        // Reset
        repeat (2) @(posedge clk);
        #1 preload = 1'b0;
        @(negedge clk);
        chk("rst_we", we, 1'b0);
        chk("rst_waddr", write_addr, '0);
        chk("rst_wdata", write_data, '0);
        chk("rst_raddr", read1_addr, '0);
        chk("rst_led", led_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", verify_err, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        wlog.delete();

        // Single write with cycle-exact latency
        sw_addr = 5'd5; sw_data = 8'hA5; key_write = 1'b1;
        lat = 0;
        for (int k = 1; k <= DEB + 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (we && lat == 0) lat = k;
            if (k == DEB + 3) begin
                chk("wr_busy", busy, 1'b1);
                chk("wr_addr_bus", write_addr, 5'd5);
                chk("wr_data_bus", write_data, 32'h000000A5);
            end
            if (k == DEB + 5) chk("wr_led_before", led_data, 8'h00);
            if (k == DEB + 6) chk("wr_led_after", led_data, 8'hA5);
            if (k == 10) key_write = 1'b0;
        end
        chk("wr_latency", lat, DEB + 3);
        @(posedge clk); #1;
        wait_idle("wr", 40);
        repeat (DEB + 4) @(posedge clk);
        #1;
        check_write_log("wr", 5'd5, 8'hA5);
        chk("wr_err", verify_err, 1'b0);
        ref_mem[5] = 8'hA5;

        // Bounce: 1,0,1 then steady high
        sw_addr = 5'd9; sw_data = 8'h42;
        key_write = 1'b1; @(posedge clk); #1;
        key_write = 1'b0; @(posedge clk); #1;
        key_write = 1'b1; @(posedge clk); #1;
        do_op("bounce", 1'b1, 1'b0, 10);
        check_write_log("bounce", 5'd9, 8'h42);
        ref_mem[9] = 8'h42;

        // Table-driven writes
        foreach (vecs[i]) begin
            sw_addr = vecs[i].addr;
            sw_data = vecs[i].data;
            do_op($sformatf("tbl%0d", i), 1'b1, 1'b0, vecs[i].hold);
            chk($sformatf("tbl%0d_count", i), wlog.size(), 1);
            if (wlog.size() > 0) begin
                chk($sformatf("tbl%0d_addr", i), wlog[0].addr, vecs[i].addr);
                chk($sformatf("tbl%0d_wdata", i), wlog[0].data, vecs[i].exp_wdata);
            end
            wlog.delete();
            chk($sformatf("tbl%0d_led", i), led_data, vecs[i].exp_led);
            chk($sformatf("tbl%0d_err", i), verify_err, 1'b0);
            ref_mem[vecs[i].addr] = vecs[i].data;
        end
        live_check("live_5", 5'd5, ref_mem[5]);
        live_check("live_9", 5'd9, ref_mem[9]);

        // Clear over a register file full of 0xFF
        @(posedge clk); #1 preload = 1'b1; pre_val = 32'hFF;
        @(posedge clk); #1 preload = 1'b0;
        do_op("clear", 1'b0, 1'b1, 8);
        check_clear_log("clear", NREG);
        for (int i = 0; i < NREG; i++) ref_mem[i] = 8'h00;
        live_check("clear_live13", 5'd13, 8'h00);
        live_check("clear_live31", 5'd31, 8'h00);

        // Both keys in the same cycle: clear wins
        sw_addr = 5'd4; sw_data = 8'h77;
        do_op("coll", 1'b1, 1'b1, 8);
        check_clear_log("coll", NREG);

        // Write pressed during a clear is dropped
        key_clear = 1'b1;
        repeat (6) @(posedge clk);
        #1 key_clear = 1'b0;
        repeat (6) @(posedge clk);
        #1 key_write = 1'b1;
        repeat (10) @(posedge clk);
        #1 key_write = 1'b0;
        wait_idle("busydrop", 60);
        repeat (DEB + 4) @(posedge clk);
        #1;
        check_clear_log("busydrop", NREG);
        live_check("busydrop_live4", 5'd4, 8'h00);

        // Randomized commands against the shadow contents
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                do_op($sformatf("rnd%0d_clr", it), 1'b0, 1'b1, $urandom_range(DEB, 12));
                check_clear_log($sformatf("rnd%0d_clr", it), NREG);
                for (int i = 0; i < NREG; i++) ref_mem[i] = 8'h00;
            end else begin
                ra = AW'($urandom_range(0, NREG - 1));
                rd = 8'($urandom);
                sw_addr = ra; sw_data = rd;
                do_op($sformatf("rnd%0d_wr", it), 1'b1, 1'b0, $urandom_range(DEB, 12));
                check_write_log($sformatf("rnd%0d_wr", it), ra, rd);
                chk($sformatf("rnd%0d_led", it), led_data, rd);
                ref_mem[ra] = rd;
            end
            ra = AW'($urandom_range(0, NREG - 1));
            live_check($sformatf("rnd%0d_live", it), ra, ref_mem[ra]);
        end
        chk("rnd_err", verify_err, 1'b0);

        // Corrupted readback sets a sticky error
        corrupt7 = 1'b1;
        sw_addr = 5'd7; sw_data = 8'h5A;
        do_op("corrupt", 1'b1, 1'b0, 8);
        check_write_log("corrupt", 5'd7, 8'h5A);
        chk("corrupt_led", led_data, 8'h5B);
        chk("corrupt_err", verify_err, 1'b1);
        corrupt7 = 1'b0;
        sw_addr = 5'd3; sw_data = 8'h11;
        do_op("sticky", 1'b1, 1'b0, 8);
        check_write_log("sticky", 5'd3, 8'h11);
        chk("sticky_err", verify_err, 1'b1);

        // Reset on the edge that would advance the clear to addr 10
        @(posedge clk); #1 preload = 1'b1; pre_val = 32'hFF;
        @(posedge clk); #1 preload = 1'b0;
        wlog.delete();
        key_clear = 1'b1;
        repeat (6) @(posedge clk);
        #1 key_clear = 1'b0;
        t = 0;
        @(negedge clk);
        while (!(we === 1'b1 && write_addr == 5'd9) && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("rstclr_reach9", write_addr, 5'd9);
        rst = 1'b1;
        @(negedge clk);
        chk("rstclr_we", we, 1'b0);
        chk("rstclr_busy", busy, 1'b0);
        chk("rstclr_err", verify_err, 1'b0);
        chk("rstclr_waddr", write_addr, '0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check_clear_log("rstclr", 10);
        begin
            bit ok = 1'b1;
            for (int i = 0; i < NREG; i++) begin
                if (mem[i] !== ((i < 10) ? 32'h0 : 32'hFF)) ok = 1'b0;
            end
            chk("rstclr_regs", ok, 1'b1);
        end
        chk("rstclr_idle_busy", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard stop in case a wait loop above is somehow bypassed.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
